// File: rtl/myfilter_pkg.sv
// Shared filter constants: tap count, coefficient table, datapath widths, ALU command encoding.
package myfilter_pkg;

    localparam int DATABITS  = 8;
    localparam int ACCBITS   = 20;
    localparam int TAPS      = 4;
    localparam int ACC_SHIFT = 0;
    localparam int IDXBITS   = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef logic signed [DATABITS-1:0] sample_t;
    typedef sample_t coef_arr_t [TAPS];

    // COEFS[0] weights the newest sample.
    localparam coef_arr_t COEFS = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};

    typedef enum logic [1:0] {
        ALU_NOP = 2'd0,
        ALU_CLR = 2'd1,
        ALU_MAC = 2'd2
    } alu_cmd_t;

endpackage

// File: rtl/sample_buffer.sv
// Purpose: TAPS-deep signed delay line, position 0 newest, with one indexed read port.
// Latency: shift takes effect on the enabled edge; read port is combinational.
// Backpressure: none; the owner gates shift_en with its own handshake.
module sample_buffer
    import myfilter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift_en,
    input  sample_t            shift_dat,
    input  logic [IDXBITS-1:0] rd_idx,
    output sample_t            rd_dat
);

    sample_t line_q [TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < TAPS; t++) begin
                line_q[t] <= '0;
            end
        end else if (shift_en) begin
            line_q[0] <= shift_dat;
            for (int t = 1; t < TAPS; t++) begin
                line_q[t] <= line_q[t-1];
            end
        end
    end

    assign rd_dat = line_q[rd_idx];

endmodule

// File: rtl/filter_sequencer.sv
// Purpose: FIR sequencer driving an external MAC ALU; MYFILTER_OUT_SAT_EN saturates out_data.
// Latency: LOAD + TAPS MAC cycles, out_valid after TAPS+1 edges from acceptance; period TAPS+3.
// Backpressure: holds OUT (result stable) until out_ready; sample_ready_out only in IDLE.
module filter_sequencer
    import myfilter_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [DATABITS-1:0] sample_in,
    input  logic                       sample_valid_in,
    output logic                       sample_ready_out,
    output logic signed [DATABITS-1:0] m1_out,
    output logic signed [DATABITS-1:0] m2_out,
    output alu_cmd_t                   cmd_out,
    output logic signed [ACCBITS-1:0]  acc_out,
    input  logic signed [ACCBITS-1:0]  alu_d_in,
    output logic signed [DATABITS-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready
);

    typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;

    localparam int SLICE_HI = ACC_SHIFT + DATABITS;

    state_t                    state_q, state_d;
    logic [IDXBITS-1:0]        idx_q, idx_d;
    logic signed [ACCBITS-1:0] acc_q, acc_d;
    logic                      run_q;
    sample_t                   tap_dat;
    logic                      shift_en;

    assign shift_en = sample_valid_in && sample_ready_out;

    sample_buffer u_sample_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (shift_en),
        .shift_dat (sample_in),
        .rd_idx    (idx_q),
        .rd_dat    (tap_dat)
    );

    // run_q keeps ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        acc_d            = acc_q;
        cmd_out          = ALU_NOP;
        m1_out           = '0;
        m2_out           = '0;
        out_valid        = 1'b0;
        sample_ready_out = 1'b0;
        case (state_q)
            IDLE: begin
                sample_ready_out = run_q;
                if (sample_valid_in && run_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cmd_out = ALU_CLR;
                acc_d   = '0;
                idx_d   = '0;
                state_d = MAC;
            end
            MAC: begin
                cmd_out = ALU_MAC;
                m1_out  = tap_dat;
                m2_out  = COEFS[idx_q];
                acc_d   = alu_d_in;
                if (idx_q == IDXBITS'(TAPS - 1)) begin
                    idx_d   = '0;
                    state_d = OUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc_out = acc_q;

    always_comb begin
        out_data = acc_q[SLICE_HI-1:ACC_SHIFT];
`ifdef MYFILTER_OUT_SAT_EN
        // Overflow when the bits from the slice sign upward are not all equal.
        if ((|acc_q[ACCBITS-1:SLICE_HI-1]) && !(&acc_q[ACCBITS-1:SLICE_HI-1])) begin
            out_data = acc_q[ACCBITS-1] ? {1'b1, {(DATABITS-1){1'b0}}}
                                        : {1'b0, {(DATABITS-1){1'b1}}};
        end
`else
        out_data = acc_q[SLICE_HI-1:ACC_SHIFT];
`endif
    end

endmodule

// File: tb/tb_filter_sequencer.sv
// Directed bench for filter_sequencer with a reference MAC ALU closing the acc loop.
module tb_filter_sequencer;
    import myfilter_pkg::*;

    logic               clk;
    logic               rst_n;
    logic [7:0]         sample_in;
    logic               sample_valid_in;
    logic               sample_ready_out;
    logic [7:0]         m1_out;
    logic [7:0]         m2_out;
    alu_cmd_t           cmd_out;
    logic [ACCBITS-1:0] acc_out;
    logic [ACCBITS-1:0] alu_d;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] coef_exp [4] = '{8'd1, 8'd2, 8'd3, 8'd4};

    filter_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sample_in        (sample_in),
        .sample_valid_in  (sample_valid_in),
        .sample_ready_out (sample_ready_out),
        .m1_out           (m1_out),
        .m2_out           (m2_out),
        .cmd_out          (cmd_out),
        .acc_out          (acc_out),
        .alu_d_in         (alu_d),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready)
    );

    // Reference ALU: combinational on the current operands.
    logic signed [ACCBITS-1:0] op1, op2;
    always_comb begin
        op1 = $signed(m1_out);
        op2 = $signed(m2_out);
        case (cmd_out)
            ALU_CLR: alu_d = '0;
            ALU_MAC: alu_d = $signed(acc_out) + op1 * op2;
            default: alu_d = acc_out;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sat_or(input logic [7:0] trunc);
`ifdef MYFILTER_OUT_SAT_EN
        return 8'h7F;
`else
        return trunc;
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},  sample_ready_out, 1'b0);
        check({tag, "_ovld"}, out_valid, 1'b0);
        check({tag, "_cmd"},  cmd_out, ALU_NOP);
        check({tag, "_odat"}, out_data, 8'h00);
        check({tag, "_acc"},  acc_out, '0);
        check({tag, "_m1"},   m1_out, 8'h00);
        check({tag, "_m2"},   m2_out, 8'h00);
    endtask

    // Accept one sample and follow it to OUT, checking the command trace and latency.
    task automatic send(input logic [7:0] s, input string tag);
        int w;
        int lat;
        w = 0;
        while (sample_ready_out !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check({tag, "_rdy"}, sample_ready_out, 1'b1);
        check({tag, "_idle_cmd"}, cmd_out, ALU_NOP);
        sample_in       = s;
        sample_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0;
        sample_in       = 8'h00;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            if (lat == 0) begin
                check({tag, "_clr"}, cmd_out, ALU_CLR);
            end else if (lat <= 4) begin
                check({tag, "_mac"}, cmd_out, ALU_MAC);
                check({tag, "_coef"}, m2_out, coef_exp[lat-1]);
            end
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, 5);
        check({tag, "_out_cmd"}, cmd_out, ALU_NOP);
        check({tag, "_out_m1"}, m1_out, 8'h00);
    endtask

    task automatic take(input logic [7:0] exp, input string tag);
        check({tag, "_dat"}, out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_done"}, out_valid, 1'b0);
        check({tag, "_rerdy"}, sample_ready_out, 1'b1);
    endtask

    initial begin
        rst_n           = 1'b0;
        out_ready       = 1'b0;
        sample_valid_in = 1'b1;
        sample_in       = 8'h55;

        tick();
        tick();
        check_reset_outputs("rst");
        sample_valid_in = 1'b0;
        sample_in       = 8'h00;
        rst_n = 1'b1;
        check("rst_rel_rdy", sample_ready_out, 1'b0);
        tick();
        check("rst_first_edge_rdy", sample_ready_out, 1'b1);

        // Impulse
        send(8'd1, "imp0"); take(8'd1, "imp0");
        send(8'd0, "imp1"); take(8'd2, "imp1");
        send(8'd0, "imp2"); take(8'd3, "imp2");
        send(8'd0, "imp3"); take(8'd4, "imp3");
        send(8'd0, "imp4"); take(8'd0, "imp4");

        // Step
        send(8'd1, "stp0"); take(8'd1,  "stp0");
        send(8'd1, "stp1"); take(8'd3,  "stp1");
        send(8'd1, "stp2"); take(8'd6,  "stp2");
        send(8'd1, "stp3"); take(8'd10, "stp3");
        send(8'd1, "stp4"); take(8'd10, "stp4");

        // Back-pressure with a sample offered while not ready: line [2,1,1,1] -> 11
        send(8'd2, "bp");
        sample_in       = 8'd99;
        sample_valid_in = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_hold_dat", out_data, 8'h0B);
            check("bp_hold_vld", out_valid, 1'b1);
            check("bp_hold_rdy", sample_ready_out, 1'b0);
        end
        sample_valid_in = 1'b0;
        sample_in       = 8'h00;
        take(8'h0B, "bp");
        // Line [0,2,1,1] -> 4+3+4 = 11; the 99 must not have entered
        send(8'd0, "bp_after"); take(8'h0B, "bp_after");

        // Saturation: 137, 389, 762, 1270
        send(8'd127, "sat0"); take(sat_or(8'h89), "sat0");
        send(8'd127, "sat1"); take(sat_or(8'h85), "sat1");
        send(8'd127, "sat2"); take(sat_or(8'hFA), "sat2");
        send(8'd127, "sat3"); take(sat_or(8'hF6), "sat3");

        // Reset during MAC at tap index 2
        sample_in       = 8'd5;
        sample_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0;
        sample_in       = 8'h00;
        tick();
        tick();
        tick();
        check("mid_cmd", cmd_out, ALU_MAC);
        check("mid_coef", m2_out, 8'd3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mid_no_result", out_valid, 1'b0);
        end
        send(8'd1, "rimp0"); take(8'd1, "rimp0");
        send(8'd0, "rimp1"); take(8'd2, "rimp1");
        send(8'd0, "rimp2"); take(8'd3, "rimp2");
        send(8'd0, "rimp3"); take(8'd4, "rimp3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
